// File: rtl/clock_run.sv
// Real-time clock driven by a single system clock. Counts seconds, minutes and hours (0..23)
// from a programmable divider, with an atomic time-set path and a 1 Hz indicator.
module clock_run #(
  parameter int unsigned CLK_DIV = 50000000
) (
  input  logic       CLK_50,
  input  logic       reset_en,
  input  logic       run_en,
  input  logic       set_en,
  input  logic [5:0] hour_set,
  input  logic [5:0] minute_set,
  input  logic [5:0] second_set,
  output logic [5:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic       clock_clk,
  output logic       sec_tick
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;
  logic [5:0]       hour_nxt;
  logic [5:0]       minute_nxt;
  logic [5:0]       second_nxt;
  logic             clock_clk_nxt;
  logic             set_valid;
  logic             advance;

  assign set_valid = (hour_set <= 6'd23) && (minute_set <= 6'd59) && (second_set <= 6'd59);
  assign advance   = run_en && !set_en && (div_cnt == DIV_LAST);
  assign sec_tick  = advance;

  always_comb begin
    div_nxt    = div_cnt;
    hour_nxt   = hour;
    minute_nxt = minute;
    second_nxt = second;

    if (set_en) begin
      // An invalid load still restarts the second so timing stays aligned to the strobe.
      div_nxt = '0;
      if (set_valid) begin
        hour_nxt   = hour_set;
        minute_nxt = minute_set;
        second_nxt = second_set;
      end
    end else if (run_en) begin
      if (advance) begin
        div_nxt = '0;
        // >= comparisons keep every field inside its range even from a corrupted state.
        if (second >= 6'd59) begin
          second_nxt = '0;
          if (minute >= 6'd59) begin
            minute_nxt = '0;
            hour_nxt   = (hour >= 6'd23) ? 6'd0 : hour + 6'd1;
          end else begin
            minute_nxt = minute + 6'd1;
          end
        end else begin
          second_nxt = second + 6'd1;
        end
      end else begin
        div_nxt = div_cnt + DIV_W'(1);
      end
    end

    clock_clk_nxt = (div_nxt < DIV_HALF);
  end

  always_ff @(posedge CLK_50 or negedge reset_en) begin
    if (!reset_en) begin
      div_cnt   <= '0;
      hour      <= '0;
      minute    <= '0;
      second    <= '0;
      clock_clk <= 1'b1;
    end else begin
      div_cnt   <= div_nxt;
      hour      <= hour_nxt;
      minute    <= minute_nxt;
      second    <= second_nxt;
      clock_clk <= clock_clk_nxt;
    end
  end

endmodule

// File: tb/tb_clock_run.sv
// Directed self-checking bench for clock_run with a divider of 4 cycles per second.
module tb_clock_run;

  logic       CLK_50;
  logic       reset_en;
  logic       run_en;
  logic       set_en;
  logic [5:0] hour_set;
  logic [5:0] minute_set;
  logic [5:0] second_set;
  logic [5:0] hour;
  logic [5:0] minute;
  logic [5:0] second;
  logic       clock_clk;
  logic       sec_tick;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  clock_run #(.CLK_DIV(4)) dut (
    .CLK_50    (CLK_50),
    .reset_en  (reset_en),
    .run_en    (run_en),
    .set_en    (set_en),
    .hour_set  (hour_set),
    .minute_set(minute_set),
    .second_set(second_set),
    .hour      (hour),
    .minute    (minute),
    .second    (second),
    .clock_clk (clock_clk),
    .sec_tick  (sec_tick)
  );

  initial CLK_50 = 1'b0;
  always #5 CLK_50 = ~CLK_50;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step(input int unsigned n);
    repeat (n) @(negedge CLK_50);
  endtask

  task automatic load_time(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
    set_en = 1'b1;
    hour_set = h;
    minute_set = m;
    second_set = s;
    step(1);
    set_en = 1'b0;
  endtask

  task automatic test_reset;
    reset_en = 1'b0;
    run_en = 1'b1;
    set_en = 1'b1;
    hour_set = 6'd1;
    minute_set = 6'd2;
    second_set = 6'd3;
    step(2);
    total_cnt++;
    if ({hour, minute, second} !== 18'd0) $display("FAIL reset_time: got %0d:%0d:%0d want 0:0:0", hour, minute, second);
    else pass_cnt++;
    total_cnt++;
    if (clock_clk !== 1'b1) $display("FAIL reset_clock_clk: got %b want 1", clock_clk);
    else pass_cnt++;
    total_cnt++;
    if (sec_tick !== 1'b0) $display("FAIL reset_sec_tick: got %b want 0", sec_tick);
    else pass_cnt++;
  endtask

  task automatic test_run;
    set_en = 1'b0;
    reset_en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      total_cnt++;
      if (sec_tick !== ((k % 4) == 3)) $display("FAIL run_sec_tick[%0d]: got %b want %b", k, sec_tick, ((k % 4) == 3));
      else pass_cnt++;
      total_cnt++;
      if (clock_clk !== ((k % 4) < 2)) $display("FAIL run_clock_clk[%0d]: got %b want %b", k, clock_clk, ((k % 4) < 2));
      else pass_cnt++;
      total_cnt++;
      if (second !== 6'(k / 4)) $display("FAIL run_second[%0d]: got %0d want %0d", k, second, k / 4);
      else pass_cnt++;
      step(1);
    end
  endtask

  task automatic test_set_rollover;
    load_time(6'd23, 6'd59, 6'd58);
    total_cnt++;
    if ({hour, minute, second} !== {6'd23, 6'd59, 6'd58} || clock_clk !== 1'b1)
      $display("FAIL set_load: got %0d:%0d:%0d clk %b want 23:59:58 clk 1", hour, minute, second, clock_clk);
    else pass_cnt++;
    step(3);
    total_cnt++;
    if (sec_tick !== 1'b1 || second !== 6'd58) $display("FAIL set_tick: got tick %b sec %0d want tick 1 sec 58", sec_tick, second);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if ({hour, minute, second} !== {6'd23, 6'd59, 6'd59}) $display("FAIL roll_59: got %0d:%0d:%0d want 23:59:59", hour, minute, second);
    else pass_cnt++;
    step(4);
    total_cnt++;
    if ({hour, minute, second} !== 18'd0) $display("FAIL roll_midnight: got %0d:%0d:%0d want 0:0:0", hour, minute, second);
    else pass_cnt++;
  endtask

  task automatic test_carry;
    load_time(6'd10, 6'd59, 6'd59);
    step(4);
    total_cnt++;
    if ({hour, minute, second} !== {6'd11, 6'd0, 6'd0}) $display("FAIL carry_hour: got %0d:%0d:%0d want 11:0:0", hour, minute, second);
    else pass_cnt++;
    load_time(6'd12, 6'd34, 6'd59);
    step(4);
    total_cnt++;
    if ({hour, minute, second} !== {6'd12, 6'd35, 6'd0}) $display("FAIL carry_minute: got %0d:%0d:%0d want 12:35:0", hour, minute, second);
    else pass_cnt++;
  endtask

  task automatic test_pause;
    load_time(6'd0, 6'd0, 6'd0);
    step(2);
    total_cnt++;
    if (clock_clk !== 1'b0) $display("FAIL pause_pre_clk: got %b want 0", clock_clk);
    else pass_cnt++;
    run_en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      total_cnt++;
      if (clock_clk !== 1'b0 || sec_tick !== 1'b0 || second !== 6'd0)
        $display("FAIL pause_hold[%0d]: got clk %b tick %b sec %0d want clk 0 tick 0 sec 0", k, clock_clk, sec_tick, second);
      else pass_cnt++;
    end
    run_en = 1'b1;
    step(1);
    total_cnt++;
    if (sec_tick !== 1'b1 || second !== 6'd0) $display("FAIL pause_resume_tick: got tick %b sec %0d want tick 1 sec 0", sec_tick, second);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (second !== 6'd1 || clock_clk !== 1'b1) $display("FAIL pause_resume_adv: got sec %0d clk %b want sec 1 clk 1", second, clock_clk);
    else pass_cnt++;
    run_en = 1'b0;
    load_time(6'd3, 6'd4, 6'd5);
    step(5);
    total_cnt++;
    if ({hour, minute, second} !== {6'd3, 6'd4, 6'd5} || clock_clk !== 1'b1)
      $display("FAIL set_while_stopped: got %0d:%0d:%0d clk %b want 3:4:5 clk 1", hour, minute, second, clock_clk);
    else pass_cnt++;
    run_en = 1'b1;
  endtask

  task automatic test_bad_set;
    load_time(6'd5, 6'd6, 6'd7);
    step(2);
    total_cnt++;
    if (clock_clk !== 1'b0) $display("FAIL bad_pre_clk: got %b want 0", clock_clk);
    else pass_cnt++;
    load_time(6'd24, 6'd6, 6'd7);
    total_cnt++;
    if ({hour, minute, second} !== {6'd5, 6'd6, 6'd7}) $display("FAIL bad_hour_hold: got %0d:%0d:%0d want 5:6:7", hour, minute, second);
    else pass_cnt++;
    total_cnt++;
    if (clock_clk !== 1'b1 || sec_tick !== 1'b0) $display("FAIL bad_div_clear: got clk %b tick %b want clk 1 tick 0", clock_clk, sec_tick);
    else pass_cnt++;
    step(3);
    total_cnt++;
    if (sec_tick !== 1'b1 || second !== 6'd7) $display("FAIL bad_full_second: got tick %b sec %0d want tick 1 sec 7", sec_tick, second);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (second !== 6'd8) $display("FAIL bad_advance: got sec %0d want 8", second);
    else pass_cnt++;
    load_time(6'd1, 6'd60, 6'd0);
    total_cnt++;
    if ({hour, minute, second} !== {6'd5, 6'd6, 6'd8}) $display("FAIL bad_minute_hold: got %0d:%0d:%0d want 5:6:8", hour, minute, second);
    else pass_cnt++;
    load_time(6'd1, 6'd2, 6'd60);
    total_cnt++;
    if ({hour, minute, second} !== {6'd5, 6'd6, 6'd8}) $display("FAIL bad_second_hold: got %0d:%0d:%0d want 5:6:8", hour, minute, second);
    else pass_cnt++;
  endtask

  task automatic test_async_reset;
    load_time(6'd8, 6'd9, 6'd10);
    total_cnt++;
    if ({hour, minute, second} !== {6'd8, 6'd9, 6'd10}) $display("FAIL ar_load: got %0d:%0d:%0d want 8:9:10", hour, minute, second);
    else pass_cnt++;
    step(1);
    #2 reset_en = 1'b0;
    #1;
    total_cnt++;
    if ({hour, minute, second} !== 18'd0 || clock_clk !== 1'b1 || sec_tick !== 1'b0)
      $display("FAIL ar_immediate: got %0d:%0d:%0d clk %b tick %b want 0:0:0 clk 1 tick 0", hour, minute, second, clock_clk, sec_tick);
    else pass_cnt++;
    set_en = 1'b1;
    hour_set = 6'd9;
    minute_set = 6'd9;
    second_set = 6'd9;
    step(2);
    total_cnt++;
    if ({hour, minute, second} !== 18'd0) $display("FAIL ar_priority: got %0d:%0d:%0d want 0:0:0", hour, minute, second);
    else pass_cnt++;
    set_en = 1'b0;
    reset_en = 1'b1;
    step(3);
    total_cnt++;
    if (sec_tick !== 1'b1 || second !== 6'd0) $display("FAIL ar_resume_tick: got tick %b sec %0d want tick 1 sec 0", sec_tick, second);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if ({hour, minute, second} !== {6'd0, 6'd0, 6'd1}) $display("FAIL ar_resume: got %0d:%0d:%0d want 0:0:1", hour, minute, second);
    else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_run;
    test_set_rollover;
    test_carry;
    test_pause;
    test_bad_set;
    test_async_reset;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
